// File: rtl/egrs_spim_avmm_arbiter.sv
// rtl/egrs_spim_avmm_arbiter.sv - two-requester burst-aware AVMM arbiter for the egress SPI master port
module egrs_spim_avmm_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BRST_WIDTH = 7,
  parameter int RD_TIMEOUT = 1023,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_write,
  input  logic                  m0_read,
  input  logic [BRST_WIDTH-1:0] m0_burstcnt,
  input  logic [DATA_WIDTH-1:0] m0_wrdata,
  output logic [DATA_WIDTH-1:0] m0_rddata,
  output logic                  m0_rddvld,
  output logic                  m0_waitreq,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_write,
  input  logic                  m1_read,
  input  logic [BRST_WIDTH-1:0] m1_burstcnt,
  input  logic [DATA_WIDTH-1:0] m1_wrdata,
  output logic [DATA_WIDTH-1:0] m1_rddata,
  output logic                  m1_rddvld,
  output logic                  m1_waitreq,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_write,
  output logic                  s_read,
  output logic [BRST_WIDTH-1:0] s_burstcnt,
  output logic [DATA_WIDTH-1:0] s_wrdata,
  input  logic [DATA_WIDTH-1:0] s_rddata,
  input  logic                  s_rddvld,
  input  logic                  s_waitreq,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  rd_timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB_WR,
    ST_WR_BURST,
    ST_ARB_RD,
    ST_RD_DATA
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  r_grant_id, w_grant_id_nxt;
  logic [BRST_WIDTH-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [BRST_WIDTH-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_wd_cnt, w_wd_cnt_nxt;

  logic                  w_own_write, w_own_read;
  logic [ADDR_WIDTH-1:0] w_own_addr;
  logic [BRST_WIDTH-1:0] w_own_burst, w_own_burst_eff;
  logic [DATA_WIDTH-1:0] w_own_wrdata;
  logic                  w_wr_phase, w_rd_cmd, w_rd_data, w_cmd_phase, w_active;
  logic                  w_wr_acc, w_rd_acc, w_timeout;
  logic                  w_req0, w_req1, w_winner, w_win_write;

  // Owner mux: everything sent to the slave comes from the registered grant holder.
  assign w_own_write  = r_grant_id ? m1_write    : m0_write;
  assign w_own_read   = r_grant_id ? m1_read     : m0_read;
  assign w_own_addr   = r_grant_id ? m1_addr     : m0_addr;
  assign w_own_burst  = r_grant_id ? m1_burstcnt : m0_burstcnt;
  assign w_own_wrdata = r_grant_id ? m1_wrdata   : m0_wrdata;
  // A zero burstcount is a single-beat transfer.
  assign w_own_burst_eff = (w_own_burst == '0) ? BRST_WIDTH'(1) : w_own_burst;

  assign w_wr_phase  = (r_state == ST_ARB_WR) || (r_state == ST_WR_BURST);
  assign w_rd_cmd    = (r_state == ST_ARB_RD);
  assign w_rd_data   = (r_state == ST_RD_DATA);
  assign w_cmd_phase = w_wr_phase || w_rd_cmd;
  assign w_active    = (r_state != ST_IDLE);

  // Slave strobes only depend on requester inputs once a grant state is registered.
  assign s_write    = w_wr_phase & w_own_write;
  assign s_read     = w_rd_cmd & w_own_read;
  assign s_addr     = w_active ? w_own_addr   : '0;
  assign s_burstcnt = w_active ? w_own_burst  : '0;
  assign s_wrdata   = w_active ? w_own_wrdata : '0;

  assign m0_waitreq = (w_cmd_phase && !r_grant_id) ? s_waitreq : 1'b1;
  assign m1_waitreq = (w_cmd_phase &&  r_grant_id) ? s_waitreq : 1'b1;
  assign m0_rddata  = s_rddata;
  assign m1_rddata  = s_rddata;
  assign m0_rddvld  = w_rd_data & !r_grant_id & s_rddvld;
  assign m1_rddvld  = w_rd_data &  r_grant_id & s_rddvld;

  assign w_wr_acc  = s_write & !s_waitreq;
  assign w_rd_acc  = s_read & !s_waitreq;
  // A beat arriving on the expiry cycle still counts, so it wins over the abort.
  assign w_timeout = w_rd_data & !s_rddvld & (r_wd_cnt == CNT_WIDTH'(RD_TIMEOUT));

  assign grant_id       = r_grant_id;
  assign busy           = w_active;
  assign rd_timeout_err = w_timeout;

  assign w_req0      = m0_write | m0_read;
  assign w_req1      = m1_write | m1_read;
  assign w_winner    = (w_req0 && w_req1) ? !r_last_grant : w_req1;
  assign w_win_write = w_winner ? m1_write : m0_write;

  // Next-state logic: arbitration, burst beat counting and read watchdog.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_id_nxt   = r_grant_id;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_rd_cnt_nxt     = r_rd_cnt;
    w_wd_cnt_nxt     = r_wd_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          w_grant_id_nxt = w_winner;
          w_state_nxt    = w_win_write ? ST_ARB_WR : ST_ARB_RD;
        end
      end
      ST_ARB_WR: begin
        if (w_wr_acc) begin
          if (w_own_burst_eff == BRST_WIDTH'(1)) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant_id;
          end else begin
            w_beat_cnt_nxt = w_own_burst_eff - BRST_WIDTH'(1);
            w_state_nxt    = ST_WR_BURST;
          end
        end
      end
      ST_WR_BURST: begin
        if (w_wr_acc) begin
          w_beat_cnt_nxt = r_beat_cnt - BRST_WIDTH'(1);
          if (r_beat_cnt == BRST_WIDTH'(1)) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant_id;
          end
        end
      end
      ST_ARB_RD: begin
        if (w_rd_acc) begin
          w_rd_cnt_nxt = w_own_burst_eff;
          w_wd_cnt_nxt = '0;
          w_state_nxt  = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (s_rddvld) begin
          w_rd_cnt_nxt = r_rd_cnt - BRST_WIDTH'(1);
          w_wd_cnt_nxt = '0;
          if (r_rd_cnt == BRST_WIDTH'(1)) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = r_grant_id;
          end
        end else if (w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant_id;
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + CNT_WIDTH'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any partial burst immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_beat_cnt   <= '0;
      r_rd_cnt     <= '0;
      r_wd_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_rd_cnt     <= w_rd_cnt_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_egrs_spim_avmm_arbiter.sv
// tb/tb_egrs_spim_avmm_arbiter.sv - self-checking bench for egrs_spim_avmm_arbiter
module tb_egrs_spim_avmm_arbiter;

  localparam int TMO = 20;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [9:0]  M0A  = 10'h010;
  localparam logic [9:0]  M1A  = 10'h155;
  localparam logic [31:0] M1WD = 32'hBBBB_0001;

  logic        clk, reset;
  logic [9:0]  m0_addr, m1_addr, s_addr;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [6:0]  m0_burstcnt, m1_burstcnt, s_burstcnt;
  logic [31:0] m0_wrdata, m1_wrdata, m0_rddata, m1_rddata, s_wrdata, s_rddata;
  logic        m0_rddvld, m1_rddvld, m0_waitreq, m1_waitreq;
  logic        s_write, s_read, s_rddvld, s_waitreq;
  logic        grant_id, busy, rd_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  egrs_spim_avmm_arbiter #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .BRST_WIDTH(7), .RD_TIMEOUT(TMO), .CNT_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_write(m0_write), .m0_read(m0_read), .m0_burstcnt(m0_burstcnt),
    .m0_wrdata(m0_wrdata), .m0_rddata(m0_rddata), .m0_rddvld(m0_rddvld), .m0_waitreq(m0_waitreq),
    .m1_addr(m1_addr), .m1_write(m1_write), .m1_read(m1_read), .m1_burstcnt(m1_burstcnt),
    .m1_wrdata(m1_wrdata), .m1_rddata(m1_rddata), .m1_rddvld(m1_rddvld), .m1_waitreq(m1_waitreq),
    .s_addr(s_addr), .s_write(s_write), .s_read(s_read), .s_burstcnt(s_burstcnt),
    .s_wrdata(s_wrdata), .s_rddata(s_rddata), .s_rddvld(s_rddvld), .s_waitreq(s_waitreq),
    .grant_id(grant_id), .busy(busy), .rd_timeout_err(rd_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        m0w;
    logic [6:0]  m0bc;
    logic [31:0] m0wd;
    logic        m1w;
    logic        e_sw;
    logic        e_w0;
    logic        e_w1;
    logic        e_busy;
    logic        e_gid;
    logic [31:0] e_wd;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic m0w, input logic [6:0] m0bc,
                              input logic [31:0] m0wd, input logic m1w, input logic e_sw,
                              input logic e_w0, input logic e_w1, input logic e_busy,
                              input logic e_gid, input logic [31:0] e_wd);
    vec_t v;
    v.rst = rst; v.m0w = m0w; v.m0bc = m0bc; v.m0wd = m0wd; v.m1w = m1w;
    v.e_sw = e_sw; v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_busy = e_busy; v.e_gid = e_gid; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, n_acc, n_dv0, n_dv1, m0_acc, dv_at_m0;
    int acc, gap_err, gid_err;
    int pulse_cyc, n_pulse, n_fwd0, n_fwd1;
    logic m1_rd_acc, m0_rd_acc, m1_granted;
    logic [31:0] exp_addr;

    reset = 1'b1;
    m0_addr = M0A; m1_addr = M1A;
    m0_write = 1'b0; m0_read = 1'b0; m1_write = 1'b0; m1_read = 1'b0;
    m0_burstcnt = 7'd0; m1_burstcnt = 7'd1;
    m0_wrdata = '0; m1_wrdata = M1WD;
    s_rddata = '0; s_rddvld = 1'b0; s_waitreq = 1'b0;
    repeat (3) step();

    // m0 4-beat write, then reset, then both requesting single beats (burstcnt 0 == 1) to show alternation
    vecs[0]  = mk(H, L, 7'd4, 32'hA000_0000, L,  L, H, H, L, L, 32'h0);
    vecs[1]  = mk(L, H, 7'd4, 32'hA000_0001, L,  L, H, H, L, L, 32'h0);
    vecs[2]  = mk(L, H, 7'd4, 32'hA000_0002, L,  H, L, H, H, L, 32'hA000_0002);
    vecs[3]  = mk(L, H, 7'd4, 32'hA000_0003, L,  H, L, H, H, L, 32'hA000_0003);
    vecs[4]  = mk(L, H, 7'd4, 32'hA000_0004, L,  H, L, H, H, L, 32'hA000_0004);
    vecs[5]  = mk(L, H, 7'd4, 32'hA000_0005, L,  H, L, H, H, L, 32'hA000_0005);
    vecs[6]  = mk(L, L, 7'd4, 32'hA000_0006, L,  L, H, H, L, L, 32'h0);
    vecs[7]  = mk(H, L, 7'd0, 32'hB000_0000, L,  L, H, H, L, L, 32'h0);
    vecs[8]  = mk(L, H, 7'd0, 32'hB000_0000, H,  L, H, H, L, L, 32'h0);
    vecs[9]  = mk(L, H, 7'd0, 32'hB000_0001, H,  H, L, H, H, L, 32'hB000_0001);
    vecs[10] = mk(L, H, 7'd0, 32'hB000_0002, H,  L, H, H, L, L, 32'h0);
    vecs[11] = mk(L, H, 7'd0, 32'hB000_0003, H,  H, H, L, H, H, M1WD);
    vecs[12] = mk(L, H, 7'd0, 32'hB000_0004, H,  L, H, H, L, H, 32'h0);
    vecs[13] = mk(L, H, 7'd0, 32'hB000_0005, H,  H, L, H, H, L, 32'hB000_0005);
    vecs[14] = mk(L, H, 7'd0, 32'hB000_0006, H,  L, H, H, L, L, 32'h0);
    vecs[15] = mk(L, H, 7'd0, 32'hB000_0007, H,  H, H, L, H, H, M1WD);
    vecs[16] = mk(L, L, 7'd0, 32'hB000_0008, L,  L, H, H, L, H, 32'h0);

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst; m0_write = vecs[i].m0w; m0_burstcnt = vecs[i].m0bc;
      m0_wrdata = vecs[i].m0wd; m1_write = vecs[i].m1w; s_waitreq = 1'b0;
      @(negedge clk);
      exp_addr = vecs[i].e_busy ? (vecs[i].e_gid ? 32'(M1A) : 32'(M0A)) : 32'h0;
      check($sformatf("v%0d s_write", i), 32'(s_write), 32'(vecs[i].e_sw));
      check($sformatf("v%0d m0_waitreq", i), 32'(m0_waitreq), 32'(vecs[i].e_w0));
      check($sformatf("v%0d m1_waitreq", i), 32'(m1_waitreq), 32'(vecs[i].e_w1));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      check($sformatf("v%0d s_wrdata", i), s_wrdata, vecs[i].e_wd);
      check($sformatf("v%0d s_addr", i), 32'(s_addr), exp_addr);
      step();
    end
    m0_write = 1'b0; m1_write = 1'b0;
    step();

    // m1 8-beat read behind 3 waitreq cycles, m0 write pending throughout
    sent = 0; n_acc = 0; n_dv0 = 0; n_dv1 = 0; m0_acc = 0; dv_at_m0 = -1; m1_rd_acc = 1'b0;
    m1_read = 1'b1; m1_burstcnt = 7'd8; m0_burstcnt = 7'd1; m0_wrdata = 32'h0000_C0DE;
    for (int i = 0; i < 40; i++) begin
      m0_write  = (i >= 1) && (m0_acc == 0);
      s_waitreq = (i >= 1) && (i <= 3);
      s_rddvld  = (i >= 6) && (i % 2 == 0) && (sent < 8);
      s_rddata  = 32'hD000_0000 + 32'(sent);
      @(negedge clk);
      if (s_read && !s_waitreq) begin n_acc++; m1_rd_acc = 1'b1; end
      if (m1_rddvld) n_dv1++;
      if (m0_rddvld) n_dv0++;
      if (s_rddvld) begin
        check("A m0_rddata bcast", m0_rddata, 32'hD000_0000 + 32'(sent));
        sent++;
      end
      if (m0_write && !m0_waitreq) begin m0_acc++; dv_at_m0 = n_dv1; end
      step();
      if (m1_rd_acc) m1_read = 1'b0;
    end
    s_rddvld = 1'b0; m0_write = 1'b0;
    check("A read accepts", 32'(n_acc), 32'd1);
    check("A m1_rddvld pulses", 32'(n_dv1), 32'd8);
    check("A m0_rddvld pulses", 32'(n_dv0), 32'd0);
    check("A m0 write accepts", 32'(m0_acc), 32'd1);
    check("A m0 after beat 8", 32'(dv_at_m0), 32'd8);

    // m1 16-beat write with toggling waitreq and a 2-cycle owner stall
    acc = 0; gap_err = 0; gid_err = 0;
    m1_burstcnt = 7'd16;
    for (int i = 0; i < 80; i++) begin
      m1_write  = (acc < 16) && !(i == 9 || i == 10);
      m1_wrdata = 32'hE000_0000 + 32'(acc);
      s_waitreq = (i % 2 == 1);
      @(negedge clk);
      if (s_write && !s_waitreq) begin
        check("B beat data", s_wrdata, 32'hE000_0000 + 32'(acc));
        acc++;
      end
      if (acc > 0 && acc < 16 && !busy) gap_err++;
      if (busy && grant_id !== 1'b1) gid_err++;
      step();
    end
    m1_write = 1'b0; s_waitreq = 1'b0;
    check("B beats accepted", 32'(acc), 32'd16);
    check("B grant released mid-burst", 32'(gap_err), 32'd0);
    check("B grant_id held", 32'(gid_err), 32'd0);
    @(negedge clk);
    check("B idle after burst", 32'(busy), 32'd0);
    step();

    // m0 2-beat read, only one beat returned: watchdog abort, late beat dropped, m1 then served
    pulse_cyc = -1; n_pulse = 0; n_fwd0 = 0; n_fwd1 = 0; m0_rd_acc = 1'b0; m1_granted = 1'b0;
    m0_read = 1'b1; m0_burstcnt = 7'd2; m1_burstcnt = 7'd1;
    for (int i = 0; i < 60; i++) begin
      s_rddvld = (i == 2) || (pulse_cyc >= 0 && i == pulse_cyc + 2);
      m1_write = (pulse_cyc >= 0) && (i >= pulse_cyc + 2) && !m1_granted;
      @(negedge clk);
      if (s_read && !s_waitreq) m0_rd_acc = 1'b1;
      if (m0_rddvld) n_fwd0++;
      if (m1_rddvld) n_fwd1++;
      if (rd_timeout_err) begin
        n_pulse++;
        if (pulse_cyc < 0) pulse_cyc = i;
      end
      if (pulse_cyc >= 0 && i == pulse_cyc + 1) check("C idle after abort", 32'(busy), 32'd0);
      if (m1_write && !m1_waitreq) m1_granted = 1'b1;
      step();
      if (m0_rd_acc) m0_read = 1'b0;
    end
    s_rddvld = 1'b0; m1_write = 1'b0;
    check("C timeout pulses", 32'(n_pulse), 32'd1);
    check("C timeout cycle", 32'(pulse_cyc), 32'(2 + TMO + 1));
    check("C m0 beats forwarded", 32'(n_fwd0), 32'd1);
    check("C m1 beats forwarded", 32'(n_fwd1), 32'd0);
    check("C m1 granted after abort", 32'(m1_granted), 32'd1);

    // reset during beat 3 of an 8-beat m1 write; m0 must win right after release
    m1_write = 1'b1; m1_burstcnt = 7'd8; m1_wrdata = M1WD; s_waitreq = 1'b0;
    step();
    @(negedge clk);
    check("D beat1 s_write", 32'(s_write), 32'd1);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; m0_write = 1'b1; m0_burstcnt = 7'd1; m0_wrdata = 32'h0000_F00D; s_rddvld = 1'b1;
    @(negedge clk);
    check("D s_write", 32'(s_write), 32'd0);
    check("D s_read", 32'(s_read), 32'd0);
    check("D s_addr", 32'(s_addr), 32'd0);
    check("D s_burstcnt", 32'(s_burstcnt), 32'd0);
    check("D s_wrdata", s_wrdata, 32'd0);
    check("D m0_waitreq", 32'(m0_waitreq), 32'd1);
    check("D m1_waitreq", 32'(m1_waitreq), 32'd1);
    check("D stray rddvld", 32'({m0_rddvld, m1_rddvld}), 32'd0);
    check("D busy", 32'(busy), 32'd0);
    check("D grant_id", 32'(grant_id), 32'd0);
    check("D rd_timeout_err", 32'(rd_timeout_err), 32'd0);
    step();
    s_rddvld = 1'b0;
    @(negedge clk);
    check("D regrant id", 32'(grant_id), 32'd0);
    check("D regrant m0_waitreq", 32'(m0_waitreq), 32'd0);
    check("D regrant m1_waitreq", 32'(m1_waitreq), 32'd1);
    check("D regrant s_wrdata", s_wrdata, 32'h0000_F00D);
    step();
    m0_write = 1'b0; m1_write = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
